pc_fetch_queue: RTL

PC_FETCH_QUEUE -- requirements
Module: pc_fetch_queue

---
 rtl/pc_fetch_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/pc_fetch_queue.sv
// Program-counter generator feeding a small prefetch queue.
// gen_pc produces sequential PCs which are queued until the consumer takes them.
// A redirect flushes the queue and restarts generation at an aligned target.
module pc_fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 STEP     = 4,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rdy,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         pc_ready,
  output logic                         pc_valid,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  // STEP is a power of two, so STEP-1 covers exactly the bits to clear.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);

  // Queue storage: never reset, only observable through entries counted in count_reg.
  logic [ADDR_W-1:0] queue_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg,  count_next;
  logic [ADDR_W-1:0] gen_pc_reg, gen_pc_next;

  logic              redirect;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] aligned_target;
  logic [ADDR_W-1:0] entry_wdata;
  logic [DEPTH-1:0]  entry_wr_en;

  // Outputs depend only on registered state and rdy.
  assign pc_valid = (count_reg != '0) && rdy;
  assign pc_o     = pc_valid ? queue_mem[rd_ptr_reg] : '0;
  assign count_o  = count_reg;

  assign redirect       = rdy && redirect_valid;
  assign pop            = pc_valid && pc_ready;
  assign push           = rdy && !redirect_valid && ((count_reg < FULL_CNT) || pop);
  assign aligned_target = redirect_pc & ALIGN_MASK;
  // A redirect always lands in entry 0; otherwise the next sequential PC is queued.
  assign entry_wdata    = redirect ? aligned_target : gen_pc_reg;

  // Per-entry write enables: entry 0 on redirect, else the entry under the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
    if (gi == 0) begin : g_first
      assign entry_wr_en[gi] = redirect || (push && (wr_ptr_reg == PTR_W'(gi)));
    end else begin : g_rest
      assign entry_wr_en[gi] = !redirect && push && (wr_ptr_reg == PTR_W'(gi));
    end
  end

  // Next-state for pointers, occupancy and generator; redirect squashes push and pop.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    gen_pc_next = gen_pc_reg;
    if (redirect) begin
      rd_ptr_next = '0;
      wr_ptr_next = PTR_W'(1);
      count_next  = CNT_W'(1);
      gen_pc_next = aligned_target + STEP_V;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        gen_pc_next = gen_pc_reg + STEP_V;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      gen_pc_reg <= RESET_PC;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      gen_pc_reg <= gen_pc_next;
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_wr_en[i]) begin
        queue_mem[i] <= entry_wdata;
      end
    end
  end

endmodule
